// File: rtl/pipeline_pkg.sv
// Shared encodings and the packed control bundle carried from Decode to Execute
// in the 5-stage RV32I pipeline.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_t;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JAL  = 2'b01,
    JMP_JALR = 2'b10
  } jump_t;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_BLTU = 3'b101,
    BR_BGEU = 3'b110
  } branch_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_control_t;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } memory_op_t;

  // A load is the only instruction whose result is not ready at the end of Execute.
  localparam logic [1:0] LOAD_RESULT_SRC = RES_MEM;

  // All-zero bundle is a NOP: no write, no store, no jump, no branch.
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [1:0] jump;
    logic [2:0] branch;
    logic [3:0] alu_control;
    logic       alu_src;
    logic [1:0] upper_op;
    logic [2:0] memory_op;
  } ctrl_t;

endpackage

// File: rtl/hazard_load_use.sv
// Combinational load-use detection; a taken branch/jump in Execute overrides the stall
// because the instruction sitting in Decode is then on the wrong path.
module hazard_load_use #(
  parameter int         ADDR_WIDTH      = 5,
  parameter logic [1:0] LOAD_RESULT_SRC = pipeline_pkg::LOAD_RESULT_SRC
) (
  input  logic                  valid_e,
  input  logic                  reg_write_e,
  input  logic [1:0]            result_src_e,
  input  logic [ADDR_WIDTH-1:0] rd_e,
  input  logic [ADDR_WIDTH-1:0] rs1_d,
  input  logic [ADDR_WIDTH-1:0] rs2_d,
  input  logic                  rs1_used_d,
  input  logic                  rs2_used_d,
  input  logic                  pc_src_e,
  output logic                  load_use,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_d
);

  logic load_in_e;
  logic rs1_hit;
  logic rs2_hit;

  // reg_write_e is already masked for rd=x0, so x0 can never produce a match here.
  assign load_in_e = valid_e && reg_write_e && (result_src_e == LOAD_RESULT_SRC);
  assign rs1_hit   = rs1_used_d && (rs1_d == rd_e);
  assign rs2_hit   = rs2_used_d && (rs2_d == rd_e);
  assign load_use  = load_in_e && (rs1_hit || rs2_hit);

  assign stall_f = load_use && !pc_src_e;
  assign stall_d = load_use && !pc_src_e;
  assign flush_d = pc_src_e;

endmodule

// File: rtl/decode_execute_reg.sv
// Decode-to-Execute pipeline register: captures the Decode bundle, or inserts a bubble
// on a taken branch/jump or a load-use hazard.
module decode_execute_reg #(
  parameter int         DATA_WIDTH      = 32,
  parameter int         ADDR_WIDTH      = 5,
  parameter logic [1:0] LOAD_RESULT_SRC = pipeline_pkg::LOAD_RESULT_SRC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  PCSrcE,
  input  logic                  RegWriteD,
  input  logic [1:0]            ResultSrcD,
  input  logic                  MemWriteD,
  input  logic [1:0]            JumpD,
  input  logic [2:0]            BranchD,
  input  logic [3:0]            ALUControlD,
  input  logic                  ALUSrcD,
  input  logic [1:0]            UpperOpD,
  input  logic [2:0]            MemoryOpD,
  input  logic [DATA_WIDTH-1:0] RD1D,
  input  logic [DATA_WIDTH-1:0] RD2D,
  input  logic [DATA_WIDTH-1:0] PCD,
  input  logic [ADDR_WIDTH-1:0] Rs1D,
  input  logic [ADDR_WIDTH-1:0] Rs2D,
  input  logic [ADDR_WIDTH-1:0] RdD,
  input  logic [DATA_WIDTH-1:0] ImmExtD,
  input  logic [DATA_WIDTH-1:0] PCPlus4D,
  input  logic                  Rs1UsedD,
  input  logic                  Rs2UsedD,
  output logic                  RegWriteE,
  output logic [1:0]            ResultSrcE,
  output logic                  MemWriteE,
  output logic [1:0]            JumpE,
  output logic [2:0]            BranchE,
  output logic [3:0]            ALUControlE,
  output logic                  ALUSrcE,
  output logic [1:0]            UpperOpE,
  output logic [2:0]            MemoryOpE,
  output logic [DATA_WIDTH-1:0] RD1E,
  output logic [DATA_WIDTH-1:0] RD2E,
  output logic [DATA_WIDTH-1:0] PCE,
  output logic [ADDR_WIDTH-1:0] Rs1E,
  output logic [ADDR_WIDTH-1:0] Rs2E,
  output logic [ADDR_WIDTH-1:0] RdE,
  output logic [DATA_WIDTH-1:0] ImmExtE,
  output logic [DATA_WIDTH-1:0] PCPlus4E,
  output logic                  ValidE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  FlushD
);

  import pipeline_pkg::ctrl_t;

  ctrl_t                 ctrl_d;
  ctrl_t                 ctrl_reg;
  logic                  valid_reg;
  logic [DATA_WIDTH-1:0] rd1_reg;
  logic [DATA_WIDTH-1:0] rd2_reg;
  logic [DATA_WIDTH-1:0] pc_reg;
  logic [DATA_WIDTH-1:0] imm_ext_reg;
  logic [DATA_WIDTH-1:0] pc_plus4_reg;
  logic [ADDR_WIDTH-1:0] rs1_reg;
  logic [ADDR_WIDTH-1:0] rs2_reg;
  logic [ADDR_WIDTH-1:0] rd_reg;
  logic                  load_use;
  logic                  bubble;

  always_comb begin
    ctrl_d             = '0;
    // Writes to x0 are dropped here so nothing downstream ever matches on x0.
    ctrl_d.reg_write   = RegWriteD && (RdD != '0);
    ctrl_d.result_src  = ResultSrcD;
    ctrl_d.mem_write   = MemWriteD;
    ctrl_d.jump        = JumpD;
    ctrl_d.branch      = BranchD;
    ctrl_d.alu_control = ALUControlD;
    ctrl_d.alu_src     = ALUSrcD;
    ctrl_d.upper_op    = UpperOpD;
    ctrl_d.memory_op   = MemoryOpD;
  end

  hazard_load_use #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .LOAD_RESULT_SRC(LOAD_RESULT_SRC)
  ) u_hazard (
    .valid_e     (valid_reg),
    .reg_write_e (ctrl_reg.reg_write),
    .result_src_e(ctrl_reg.result_src),
    .rd_e        (rd_reg),
    .rs1_d       (Rs1D),
    .rs2_d       (Rs2D),
    .rs1_used_d  (Rs1UsedD),
    .rs2_used_d  (Rs2UsedD),
    .pc_src_e    (PCSrcE),
    .load_use    (load_use),
    .stall_f     (StallF),
    .stall_d     (StallD),
    .flush_d     (FlushD)
  );

  // Flush and load-use produce the same bubble; reset is folded in with them.
  assign bubble = rst || PCSrcE || load_use;

  always_ff @(posedge clk) begin
    if (bubble) begin
      ctrl_reg     <= '0;
      valid_reg    <= 1'b0;
      rd1_reg      <= '0;
      rd2_reg      <= '0;
      pc_reg       <= '0;
      imm_ext_reg  <= '0;
      pc_plus4_reg <= '0;
      rs1_reg      <= '0;
      rs2_reg      <= '0;
      rd_reg       <= '0;
    end else begin
      ctrl_reg     <= ctrl_d;
      valid_reg    <= 1'b1;
      rd1_reg      <= RD1D;
      rd2_reg      <= RD2D;
      pc_reg       <= PCD;
      imm_ext_reg  <= ImmExtD;
      pc_plus4_reg <= PCPlus4D;
      rs1_reg      <= Rs1D;
      rs2_reg      <= Rs2D;
      rd_reg       <= RdD;
    end
  end

  assign RegWriteE   = ctrl_reg.reg_write;
  assign ResultSrcE  = ctrl_reg.result_src;
  assign MemWriteE   = ctrl_reg.mem_write;
  assign JumpE       = ctrl_reg.jump;
  assign BranchE     = ctrl_reg.branch;
  assign ALUControlE = ctrl_reg.alu_control;
  assign ALUSrcE     = ctrl_reg.alu_src;
  assign UpperOpE    = ctrl_reg.upper_op;
  assign MemoryOpE   = ctrl_reg.memory_op;
  assign RD1E        = rd1_reg;
  assign RD2E        = rd2_reg;
  assign PCE         = pc_reg;
  assign ImmExtE     = imm_ext_reg;
  assign PCPlus4E    = pc_plus4_reg;
  assign Rs1E        = rs1_reg;
  assign Rs2E        = rs2_reg;
  assign RdE         = rd_reg;
  assign ValidE      = valid_reg;

endmodule
